// File: rtl/aes_mask_pkg.sv
// aes_mask_pkg: shared widths and packer state encoding for the LFSR mask packer
package aes_mask_pkg;
  localparam int MASK_W = 128;
  localparam int BYTE_W = 8;
  localparam int DROP_W = 8;
  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;
endpackage

// File: rtl/mask_fifo.sv
// mask_fifo: DEPTH x W synchronous FIFO with registered head; ports clk, rst, i_push, i_data, i_pop, o_head, o_full, o_empty
module mask_fifo
  import aes_mask_pkg::*;
#(
  parameter int W     = MASK_W,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("mask_fifo DEPTH must be a power of 2 and >= 2");
  end
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wp, r_rp;
  logic         w_push, w_pop;
  assign o_empty = r_wp == r_rp;
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_head  = r_mem[r_rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp[AW-1:0]] <= i_data;
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
    end
  end
endmodule

// File: rtl/lfsr_mask_packer.sv
// lfsr_mask_packer: packs LFSR bytes into mask words buffered in a FIFO; ports clk, reset, rnd_byte/rnd_valid in, mask/mask_valid/mask_ready handshake, drop_cnt, health_err; optional MASK_PACK_HEALTH_EN stuck-source monitor
module lfsr_mask_packer
  import aes_mask_pkg::*;
#(
  parameter int BYTES_PER_WORD = 16,
  parameter int FIFO_DEPTH     = 2,
  parameter int STUCK_LIMIT    = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [BYTE_W-1:0]              rnd_byte,
  input  logic                           rnd_valid,
  output logic [BYTE_W*BYTES_PER_WORD-1:0] mask,
  output logic                           mask_valid,
  input  logic                           mask_ready,
  output logic [DROP_W-1:0]              drop_cnt,
  output logic                           health_err
);
  localparam int MW = BYTE_W * BYTES_PER_WORD;
  localparam int CW = $clog2(BYTES_PER_WORD);
  if (STUCK_LIMIT < 2) begin : g_bad_limit
    $error("STUCK_LIMIT must be >= 2");
  end
  state_t          r_state;
  logic [MW-1:0]   r_acc, w_acc_nxt;
  logic [CW-1:0]   r_cnt;
  logic [DROP_W-1:0] r_drop;
  logic            w_full, w_empty, w_pop, w_space, w_stuck;
  logic            w_accept, w_last, w_push, w_drop;
  assign w_pop     = mask_valid && mask_ready;
  assign w_space   = !w_full || w_pop;
  assign w_accept  = (r_state == FILL) && rnd_valid && !w_stuck;
  assign w_last    = r_cnt == CW'(BYTES_PER_WORD - 1);
  assign w_acc_nxt = {r_acc[MW-BYTE_W-1:0], rnd_byte};
  assign w_drop    = rnd_valid && !w_accept;
  // the last byte bypasses the accumulator so a word with FIFO space never enters HOLD
  assign w_push    = w_space && ((w_accept && w_last) || ((r_state == HOLD) && !w_stuck));
  assign mask_valid = !w_empty;
  assign drop_cnt   = r_drop;
  assign health_err = w_stuck;
  mask_fifo #(.W(MW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (reset),
    .i_push (w_push),
    .i_data ((r_state == HOLD) ? r_acc : w_acc_nxt),
    .i_pop  (w_pop),
    .o_head (mask),
    .o_full (w_full),
    .o_empty(w_empty)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FILL;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_drop  <= '0;
    end else begin
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + 1'b1;
      if (w_accept) begin
        r_acc <= w_acc_nxt;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last && !w_space) r_state <= HOLD;
      end else if ((r_state == HOLD) && w_push) begin
        r_state <= FILL;
      end
    end
  end
`ifdef MASK_PACK_HEALTH_EN
  localparam int RW = $clog2(STUCK_LIMIT + 1);
  logic [RW-1:0]     r_run, w_run_nxt;
  logic [BYTE_W-1:0] r_prev;
  logic              r_err;
  // run of 0 means no byte accepted yet since reset; the run stops growing once r_err freezes acceptance
  assign w_run_nxt = ((r_run != '0) && (rnd_byte == r_prev)) ? r_run + 1'b1 : RW'(1);
  assign w_stuck   = r_err;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run  <= '0;
      r_prev <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_run  <= w_run_nxt;
      r_prev <= rnd_byte;
      if (w_run_nxt == RW'(STUCK_LIMIT)) r_err <= 1'b1;
    end
  end
`else
  assign w_stuck = 1'b0;
`endif
endmodule

// File: tb/tb_lfsr_mask_packer.sv
// tb_lfsr_mask_packer: table, directed and random checks of lfsr_mask_packer against a queue-based reference model
module tb_lfsr_mask_packer;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rnd_valid = 1'b0;
  logic         mask_ready = 1'b0;
  logic [7:0]   rnd_byte = 8'h00;
  logic [127:0] mask;
  logic         mask_valid;
  logic [7:0]   drop_cnt;
  logic         health_err;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  lfsr_mask_packer dut (
    .clk       (clk),
    .reset     (reset),
    .rnd_byte  (rnd_byte),
    .rnd_valid (rnd_valid),
    .mask      (mask),
    .mask_valid(mask_valid),
    .mask_ready(mask_ready),
    .drop_cnt  (drop_cnt),
    .health_err(health_err)
  );
  logic [7:0]   part[$];
  logic [127:0] q[$];
  logic [127:0] held;
  logic [7:0]   last;
  bit           hold, herr;
  int           drop, run;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic mreset();
    part.delete();
    q.delete();
    hold = 0;
    herr = 0;
    drop = 0;
    run = 0;
  endtask
  task automatic mstep(input bit v, input logic [7:0] b, input bit r);
    bit pop, space, nerr;
    logic [127:0] w;
    pop = q.size() > 0 && r;
    space = q.size() < 2 || pop;
    nerr = herr;
    if (pop) void'(q.pop_front());
    if (hold) begin
      if (v && drop < 255) drop++;
      if (space && !herr) begin
        q.push_back(held);
        hold = 0;
      end
    end else if (v) begin
      if (herr) begin
        if (drop < 255) drop++;
      end else begin
        run = (run > 0 && b == last) ? run + 1 : 1;
        last = b;
`ifdef MASK_PACK_HEALTH_EN
        if (run == 4) nerr = 1;
`endif
        part.push_back(b);
        if (part.size() == 16) begin
          w = '0;
          foreach (part[i]) w = {w[119:0], part[i]};
          part.delete();
          if (space) q.push_back(w);
          else begin
            hold = 1;
            held = w;
          end
        end
      end
    end
    herr = nerr;
  endtask
  task automatic outs(input string n);
    chk({n, ".valid"}, {127'd0, mask_valid}, {127'd0, q.size() > 0});
    if (q.size() > 0) chk({n, ".mask"}, mask, q[0]);
    chk({n, ".drop"}, {120'd0, drop_cnt}, 128'(drop));
    chk({n, ".herr"}, {127'd0, health_err}, {127'd0, herr});
  endtask
  task automatic step(input bit v, input logic [7:0] b, input bit r, input string n);
    rnd_valid = v;
    rnd_byte = b;
    mask_ready = r;
    @(posedge clk);
    mstep(v, b, r);
    #1;
    outs(n);
  endtask
  task automatic do_reset();
    rnd_valid = 0;
    mask_ready = 0;
    #2 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    mreset();
  endtask
  typedef struct {
    bit v; logic [7:0] b; bit r; bit ev; logic [127:0] em;
  } vec_t;
  vec_t tbl[17];
  initial begin
    logic [127:0] w;
    for (int i = 0; i < 16; i++) tbl[i] = '{1, 8'(i + 1), 1, i == 15, 128'h0102030405060708090A0B0C0D0E0F10};
    tbl[16] = '{0, 8'h00, 1, 0, 128'h0};
    #3;
    chk("rst.mask", mask, 128'h0);
    chk("rst.valid", {127'd0, mask_valid}, 128'h0);
    chk("rst.drop", {120'd0, drop_cnt}, 128'h0);
    chk("rst.herr", {127'd0, health_err}, 128'h0);
    @(posedge clk);
    #1 reset = 0;
    mreset();
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].b, tbl[i].r, "t1");
      chk("t1.tbl_valid", {127'd0, mask_valid}, {127'd0, tbl[i].ev});
      if (tbl[i].ev) chk("t1.tbl_mask", mask, tbl[i].em);
      chk("t1.tbl_drop", {120'd0, drop_cnt}, 128'h0);
    end
    do_reset();
    for (int i = 0; i < 64; i++) step(1, 8'($urandom), 0, "t2");
    chk("t2.drop16", {120'd0, drop_cnt}, 128'd16);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, "t2.drain");
    chk("t2.empty", {127'd0, mask_valid}, 128'h0);
    do_reset();
    for (int i = 0; i < 47; i++) step(1, 8'($urandom), 0, "t3");
    step(1, 8'h5A, 1, "t3.last");
    chk("t3.nodrop", {120'd0, drop_cnt}, 128'h0);
    chk("t3.valid", {127'd0, mask_valid}, 128'h1);
    do_reset();
    for (int i = 0; i < 7; i++) step(1, 8'hEE, 1, "t4");
    #2 reset = 1;
    #1;
    chk("t4.mask", mask, 128'h0);
    chk("t4.valid", {127'd0, mask_valid}, 128'h0);
    chk("t4.drop", {120'd0, drop_cnt}, 128'h0);
    @(posedge clk);
    #1 reset = 0;
    mreset();
    w = '0;
    for (int i = 0; i < 16; i++) begin
      w = {w[119:0], 8'(8'h21 + i)};
      step(1, 8'(8'h21 + i), 0, "t4.word");
    end
    chk("t4.fresh", mask, w);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 8'hA5, 1, "t5");
`ifdef MASK_PACK_HEALTH_EN
    chk("t5.herr", {127'd0, health_err}, 128'h1);
`else
    chk("t5.herr", {127'd0, health_err}, 128'h0);
`endif
    for (int i = 0; i < 20; i++) step(1, 8'(i), 1, "t5.after");
`ifdef MASK_PACK_HEALTH_EN
    chk("t5.drop", {120'd0, drop_cnt}, 128'd20);
`else
    chk("t5.drop", {120'd0, drop_cnt}, 128'd0);
`endif
    do_reset();
    for (int i = 0; i < 348; i++) step(1, 8'($urandom), 0, "t6");
    chk("t6.sat", {120'd0, drop_cnt}, 128'd255);
    do_reset();
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, ($urandom_range(0, 7) == 0) ? 8'h3C : 8'($urandom),
           $urandom_range(0, 2) != 0, "rnd");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
